// File: rtl/tick_generator_bank.sv
// Bank of independent runtime-programmable tick generators. Each channel emits
// a one-cycle strobe every PERIOD clocks (periodic) or once after PERIOD clocks (one-shot).
module tick_generator_bank #(
   parameter int                NUM_CH       = 3,
   parameter int                WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_PERIOD = WIDTH'(100),
   parameter logic [NUM_CH-1:0] RESET_ENABLE = '1,
   parameter int                CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [WIDTH-1:0]  cfg_period,
   input  logic              cfg_mode,
   input  logic              cfg_en,
   input  logic [NUM_CH-1:0] restart,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] active
);

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } mode_e;

   logic [WIDTH-1:0]  period_q [NUM_CH];
   logic [WIDTH-1:0]  period_d [NUM_CH];
   logic [WIDTH-1:0]  count_q  [NUM_CH];
   logic [WIDTH-1:0]  count_d  [NUM_CH];
   mode_e             mode_q   [NUM_CH];
   mode_e             mode_d   [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] running;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         running[c] = en_q[c] && (period_q[c] != '0) && !done_q[c];
      end
   end

   // Priority per channel: cfg write > restart > counting.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         // NOTE: every next-state signal gets a default first so no latch is inferred.
         period_d[c] = period_q[c];
         mode_d[c]   = mode_q[c];
         en_d[c]     = en_q[c];
         done_d[c]   = done_q[c];
         count_d[c]  = '0;
         tick_d[c]   = 1'b0;

         if (cfg_we && (cfg_ch == CH_W'(c))) begin
            period_d[c] = cfg_period;
            mode_d[c]   = mode_e'(cfg_mode);
            en_d[c]     = cfg_en;
            done_d[c]   = 1'b0;
         end else if (restart[c]) begin
            done_d[c] = 1'b0;
         end else if (running[c]) begin
            // period-1 is only evaluated while period != 0, so it cannot wrap.
            if (count_q[c] == period_q[c] - WIDTH'(1)) begin
               tick_d[c] = 1'b1;
               if (mode_q[c] == MODE_ONESHOT) begin
                  done_d[c] = 1'b1;
               end
            end else begin
               count_d[c] = count_q[c] + WIDTH'(1);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments; the small per-channel
   // arrays are reset explicitly because they define the post-reset timebase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            period_q[c] <= RESET_PERIOD;
            mode_q[c]   <= MODE_PERIODIC;
            count_q[c]  <= '0;
         end
         en_q   <= RESET_ENABLE;
         done_q <= '0;
         tick_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            period_q[c] <= period_d[c];
            mode_q[c]   <= mode_d[c];
            count_q[c]  <= count_d[c];
         end
         en_q   <= en_d;
         done_q <= done_d;
         tick_q <= tick_d;
      end
   end

   assign tick   = tick_q;
   assign active = running;

endmodule

// File: tb/tb_tick_generator_bank.sv
// Self-checking bench for tick_generator_bank: directed scenarios plus random
// configuration traffic compared against an elapsed-time reference model.
module tb_tick_generator_bank;

   localparam int NUM_CH = 3;
   localparam int WIDTH  = 8;
   localparam int RP     = 4;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_we = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [WIDTH-1:0]  cfg_period = '0;
   logic              cfg_mode = 1'b0;
   logic              cfg_en = 1'b0;
   logic [NUM_CH-1:0] restart = '0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] active;

   tick_generator_bank #(
      .NUM_CH      (NUM_CH),
      .WIDTH       (WIDTH),
      .RESET_PERIOD(WIDTH'(RP)),
      .RESET_ENABLE('1),
      .CH_W        (CH_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_period(cfg_period),
      .cfg_mode  (cfg_mode),
      .cfg_en    (cfg_en),
      .restart   (restart),
      .tick      (tick),
      .active    (active)
   );

   always #5 clk = ~clk;

   // Reference model: each channel remembers its programmed settings and the
   // number of clock edges elapsed since it was last (re)started.
   int unsigned m_per  [NUM_CH];
   bit          m_one  [NUM_CH];
   bit          m_en   [NUM_CH];
   int unsigned m_el   [NUM_CH];
   int          tick_cnt [NUM_CH];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [NUM_CH-1:0] obs,
                        input logic [NUM_CH-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_per[c] = RP;
         m_one[c] = 1'b0;
         m_en[c]  = 1'b1;
         m_el[c]  = 0;
      end
   endfunction

   function automatic logic [NUM_CH-1:0] exp_tick();
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!m_en[c] || m_per[c] == 0 || m_el[c] == 0) v[c] = 1'b0;
         else if (m_one[c]) v[c] = (m_el[c] == m_per[c]);
         else v[c] = (m_el[c] % m_per[c]) == 0;
      end
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_active();
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) begin
         v[c] = m_en[c] && (m_per[c] != 0) && !(m_one[c] && m_el[c] >= m_per[c]);
      end
      return v;
   endfunction

   // One clock: update the model from the inputs seen at the rising edge,
   // then compare on the falling edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
               m_per[c] = cfg_period;
               m_one[c] = cfg_mode;
               m_en[c]  = cfg_en;
               m_el[c]  = 0;
            end else if (restart[c]) begin
               m_el[c] = 0;
            end else begin
               m_el[c]++;
            end
         end
      end
      @(negedge clk);
      check({tag, ".tick"}, tick, exp_tick());
      check({tag, ".active"}, active, exp_active());
      for (int c = 0; c < NUM_CH; c++) tick_cnt[c] += int'(tick[c]);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic write(input string tag, input int ch, input int per,
                        input bit one, input bit en);
      cfg_we     = 1'b1;
      cfg_ch     = CH_W'(ch);
      cfg_period = WIDTH'(per);
      cfg_mode   = one;
      cfg_en     = en;
      cycle(tag);
      cfg_we     = 1'b0;
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NUM_CH; c++) tick_cnt[c] = 0;
   endtask

   initial begin
      model_reset();
      clear_counts();

      // Reset state and defaults.
      #12;
      check("reset.tick", tick, 3'b000);
      check("reset.active", active, 3'b111);
      @(negedge clk);
      rst_n = 1'b1;
      clear_counts();
      run("defaults", 13);
      check("defaults.count0", 3'(tick_cnt[0]), 3'd3);

      // Periodic rewrite of channel 1.
      write("wr_ch1", 1, 5, 1'b0, 1'b1);
      clear_counts();
      run("ch1_p5", 15);
      check("ch1_p5.count", 3'(tick_cnt[1]), 3'd3);

      // One-shot on channel 2, then re-arm with restart.
      write("wr_ch2", 2, 3, 1'b1, 1'b1);
      clear_counts();
      run("ch2_os", 6);
      check("ch2_os.count", 3'(tick_cnt[2]), 3'd1);
      restart = 3'b100;
      cycle("restart2");
      restart = '0;
      run("ch2_rearm", 6);
      check("ch2_rearm.count", 3'(tick_cnt[2]), 3'd2);

      // Period 0 and period 1.
      write("wr_p0", 0, 0, 1'b0, 1'b1);
      write("wr_p1", 1, 1, 1'b0, 1'b1);
      clear_counts();
      run("p0_p1", 6);
      check("p0_p1.count0", 3'(tick_cnt[0]), 3'd0);
      check("p0_p1.count1", 3'(tick_cnt[1]), 3'd6);

      // Restart landing on the tick edge suppresses that tick.
      write("wr_ch0", 0, 4, 1'b0, 1'b1);
      run("pre_restart", 3);
      clear_counts();
      restart = 3'b001;
      cycle("restart_edge");
      restart = '0;
      check("restart_edge.tick0", 3'(tick_cnt[0]), 3'd0);
      run("post_restart", 4);

      // Write and restart in the same cycle: write wins.
      restart = 3'b010;
      write("wr_and_restart", 1, 2, 1'b0, 1'b1);
      restart = '0;
      run("after_wr_rs", 5);

      // Disable via write.
      write("wr_dis", 2, 3, 1'b0, 1'b0);
      run("disabled", 4);

      // Out-of-range channel is ignored.
      write("wr_ch3", 3, 7, 1'b1, 1'b0);
      run("ignored", 6);

      // Maximum period for WIDTH=8.
      write("wr_255", 0, 255, 1'b0, 1'b1);
      clear_counts();
      run("p255", 520);
      check("p255.count", 3'(tick_cnt[0]), 3'd2);

      // Reset asserted mid-count clears ticks immediately.
      write("wr_p1_again", 1, 1, 1'b0, 1'b1);
      run("pre_reset", 2);
      rst_n = 1'b0;
      #1;
      check("midreset.tick", tick, 3'b000);
      check("midreset.active", active, 3'b111);
      model_reset();
      run("in_reset", 2);
      rst_n = 1'b1;
      run("after_reset", 9);

      // Random configuration traffic.
      for (int i = 0; i < 3000; i++) begin
         cfg_we     = ($urandom_range(0, 19) == 0);
         cfg_ch     = CH_W'($urandom_range(0, 3));
         cfg_period = ($urandom_range(0, 9) < 9) ? WIDTH'($urandom_range(0, 9))
                                                 : WIDTH'($urandom_range(250, 255));
         cfg_mode   = 1'($urandom_range(0, 1));
         cfg_en     = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < NUM_CH; c++) restart[c] = ($urandom_range(0, 15) == 0);
         cycle("random");
      end
      cfg_we  = 1'b0;
      restart = '0;
      run("drain", 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
